apb_master_interface: RTL and testbench

APB initiator that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers. It drives the APB slave interface of the I2C controller, including its register map (transmit, slave address, command, prescale, status and receive registers). It is used by the on-chip sequencer and by system-level benches as the bus-side counterpart of that slave. Single outstanding transfer; the response carries read data and an error flag.

---
 rtl/apb_master_interface.sv | 149 ++++++++++++++
 tb/tb_apb_master_interface.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_interface.sv
// APB initiator: turns a valid/ready command stream into APB SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_interface #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  pwrite_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_reg, state_next;
  logic                  psel_reg, psel_next;
  logic                  penable_reg, penable_next;
  logic                  pwrite_reg, pwrite_next;
  logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_error_reg, rsp_error_next;
  logic                  abort;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

  // Abort on the limit cycle only if the slave is still not ready.
  assign abort = (state_reg == ACCESS) && !pready_i &&
                 (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_reg == SETUP)
      wait_cnt_next = '0;
    else if (state_reg == ACCESS && !pready_i && !abort)
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) wait_cnt_reg <= '0;
    else            wait_cnt_reg <= wait_cnt_next;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_error_next = rsp_error_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid_i) begin
          state_next   = SETUP;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          pwrite_next  = cmd_write_i;
          paddr_next   = cmd_addr_i;
          pwdata_next  = cmd_wdata_i;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (pready_i) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = pwrite_reg ? '0 : prdata_i;
          rsp_error_next = 1'b0;
        end else if (abort) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_error_next = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        psel_next    = 1'b0;
        penable_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_reg     <= IDLE;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_error_reg <= rsp_error_next;
    end
  end

  assign cmd_ready_o = (state_reg == IDLE);
  assign psel_o      = psel_reg;
  assign penable_o   = penable_reg;
  assign pwrite_o    = pwrite_reg;
  assign paddr_o     = paddr_reg;
  assign pwdata_o    = pwdata_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_error_o = rsp_error_reg;

endmodule

// File: tb/tb_apb_master_interface.sv
// Randomized self-checking bench for apb_master_interface; expected timeline per
// transfer is derived from command fields and the programmed number of wait states.
module tb_apb_master_interface;

  localparam int TIMEOUT = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         waits;
  } cmd_t;

  logic       pclk_i = 1'b0;
  logic       preset_ni;
  logic       cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [7:0] cmd_addr_i, cmd_wdata_i;
  logic       rsp_valid_o, rsp_error_o;
  logic [7:0] rsp_rdata_o;
  logic [7:0] paddr_o, pwdata_o, prdata_i;
  logic       pwrite_o, psel_o, penable_o, pready_i;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  always #5 pclk_i = ~pclk_i;

  apb_master_interface #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .pclk_i(pclk_i), .preset_ni(preset_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (txn %0d)", tag, got, exp, txn_no);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   cmd_ready_o, 1);
    check({tag, "_psel"},    psel_o, 0);
    check({tag, "_penable"}, penable_o, 0);
    check({tag, "_pwrite"},  pwrite_o, 0);
    check({tag, "_paddr"},   paddr_o, 0);
    check({tag, "_pwdata"},  pwdata_o, 0);
    check({tag, "_rvalid"},  rsp_valid_o, 0);
    check({tag, "_rdata"},   rsp_rdata_o, 0);
    check({tag, "_rerror"},  rsp_error_o, 0);
  endtask

  function automatic cmd_t gen_cmd();
    cmd_t c;
    c.wr    = 1'($urandom_range(0, 1));
    c.addr  = 8'($urandom);
    c.wdata = 8'($urandom);
    c.rdata = 8'($urandom);
    c.waits = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
    return c;
  endfunction

  // Entered and left at a falling edge. If has_next, the next command is held
  // on the command port from SETUP onward and must be taken in the response cycle.
  task automatic run_txn(input cmd_t c, input bit pre, input bit has_next, input cmd_t nx);
    int         n;
    bit         tmo;
    logic [7:0] exp_rd;
    txn_no++;
    if (!pre) begin
      cmd_valid_i = 1'b1;
      cmd_write_i = c.wr;
      cmd_addr_i  = c.addr;
      cmd_wdata_i = c.wdata;
    end
    n = 0;
    while (cmd_ready_o !== 1'b1 && n < 40) begin
      @(negedge pclk_i);
      n++;
    end
    check("accept_delay", n, 0);

    @(negedge pclk_i);
    check("setup_psel", psel_o, 1);
    check("setup_penable", penable_o, 0);
    check("setup_ready", cmd_ready_o, 0);
    check("setup_paddr", paddr_o, c.addr);
    check("setup_pwrite", pwrite_o, c.wr);
    check("setup_pwdata", pwdata_o, c.wdata);
    check("setup_rvalid", rsp_valid_o, 0);
    if (has_next) begin
      cmd_write_i = nx.wr;
      cmd_addr_i  = nx.addr;
      cmd_wdata_i = nx.wdata;
    end else begin
      cmd_valid_i = 1'b0;
    end
    pready_i = 1'($urandom);
    prdata_i = 8'($urandom);

    tmo = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge pclk_i);
      check("acc_psel", psel_o, 1);
      check("acc_penable", penable_o, 1);
      check("acc_ready", cmd_ready_o, 0);
      check("acc_paddr", paddr_o, c.addr);
      check("acc_pwrite", pwrite_o, c.wr);
      check("acc_pwdata", pwdata_o, c.wdata);
      check("acc_rvalid", rsp_valid_o, 0);
      if (k == c.waits) begin
        pready_i = 1'b1;
        prdata_i = c.rdata;
        break;
      end
      pready_i = 1'b0;
      prdata_i = 8'($urandom);
      if (TMO_EN && k == TIMEOUT - 1) begin
        tmo = 1'b1;
        break;
      end
    end

    @(negedge pclk_i);
    exp_rd = (tmo || c.wr) ? 8'h00 : c.rdata;
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_error", rsp_error_o, 32'(tmo));
    check("rsp_rdata", rsp_rdata_o, exp_rd);
    check("rsp_psel", psel_o, 0);
    check("rsp_penable", penable_o, 0);
    check("rsp_ready", cmd_ready_o, 1);
    check("rsp_paddr_hold", paddr_o, c.addr);
    $display("txn %0d: %s addr=%02h wdata=%02h waits=%0d -> rdata=%02h err=%0b next_held=%0b",
             txn_no, c.wr ? "WR" : "RD", c.addr, c.wdata, c.waits, rsp_rdata_o, rsp_error_o,
             has_next);
    pready_i = 1'($urandom);
    prdata_i = 8'($urandom);
    if (!has_next) begin
      @(negedge pclk_i);
      check("post_rvalid", rsp_valid_o, 0);
      check("post_rdata_hold", rsp_rdata_o, exp_rd);
      check("post_psel", psel_o, 0);
    end
  endtask

  initial begin
    cmd_t a, b, cur, nx;
    bit   pre, hn;
    int   seen;

    preset_ni   = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    prdata_i    = '0;
    pready_i    = 1'b0;
    repeat (2) @(negedge pclk_i);
    check_reset_outputs("reset");
    preset_ni = 1'b1;
    @(negedge pclk_i);

    a = '{1'b1, 8'hC0, 8'h92, 8'h00, 0};
    run_txn(a, 1'b0, 1'b0, a);
    a = '{1'b0, 8'hE1, 8'h00, 8'hAA, 0};
    run_txn(a, 1'b0, 1'b0, a);
    a = '{1'b0, 8'hE1, 8'h00, 8'hF1, 3};
    run_txn(a, 1'b0, 1'b0, a);
    a = '{1'b1, 8'hC0, 8'h37, 8'h00, 2};
    b = '{1'b0, 8'hC2, 8'h00, 8'h5A, 1};
    run_txn(a, 1'b0, 1'b1, b);
    run_txn(b, 1'b1, 1'b0, b);
    // Past the limit: aborts with the timeout enabled, otherwise just waits.
    a = '{1'b0, 8'hE1, 8'h00, 8'h6C, TIMEOUT + 4};
    run_txn(a, 1'b0, 1'b0, a);
    a = '{1'b0, 8'hE3, 8'h00, 8'h3D, TIMEOUT - 1};
    run_txn(a, 1'b0, 1'b0, a);

    cur = gen_cmd();
    pre = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hn = (i < 39) && ($urandom_range(0, 1) == 1);
      nx = gen_cmd();
      run_txn(cur, pre, hn, nx);
      cur = nx;
      pre = hn;
    end

    // Reset while the slave is stalling in ACCESS.
    txn_no++;
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b1;
    cmd_addr_i  = 8'h33;
    cmd_wdata_i = 8'hA5;
    pready_i    = 1'b0;
    @(negedge pclk_i);
    cmd_valid_i = 1'b0;
    @(negedge pclk_i);
    check("mid_penable", penable_o, 1);
    #2 preset_ni = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge pclk_i);
    preset_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      pready_i = 1'($urandom);
      @(negedge pclk_i);
      if (rsp_valid_o === 1'b1 || psel_o === 1'b1) seen++;
    end
    check("post_rst_quiet", seen, 0);
    $display("txn %0d: reset during ACCESS, dropped without response", txn_no);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
